// File: rtl/jpeg_izigzag_buffer.sv
// Inverse-zigzag ping-pong buffer: zigzag-ordered 8x8 blocks in, raster order out; first word one cycle after a block fills.
// din_ready drops only while the bank to be written is still full or draining; dout holds steady while stalled.
module jpeg_izigzag_buffer #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout,
    output logic [5:0]    dout_idx,
    output logic          dout_last
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Zigzag position k -> raster address.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [5:0]    wcnt_q, wcnt_d;
    logic [5:0]    rcnt_q, rcnt_d;
    logic [DW-1:0] mem_q [2][64];

    logic          dout_valid_q, dout_valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [5:0]    dout_idx_q, dout_idx_d;
    logic          dout_last_q, dout_last_d;

    logic          wr_fire;
    logic          rd_load;
    logic          rd_avail;

    assign din_ready  = (bank_q[wb_q] == EMPTY) || (bank_q[wb_q] == FILLING);
    assign wr_fire    = din_valid && din_ready;
    assign rd_load    = !dout_valid_q || dout_ready;
    assign rd_avail   = (bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAINING);

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_idx   = dout_idx_q;
    assign dout_last  = dout_last_q;

    // Write completion and read release always target different banks, so both may land on one edge.
    always_comb begin
        bank_d       = bank_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        dout_valid_d = dout_valid_q;
        dout_d       = dout_q;
        dout_idx_d   = dout_idx_q;
        dout_last_d  = dout_last_q;

        if (wr_fire) begin
            wcnt_d = wcnt_q + 6'd1;
            if (wcnt_q == 6'd63) begin
                bank_d[wb_q] = FULL;
                wb_d         = ~wb_q;
            end else begin
                bank_d[wb_q] = FILLING;
            end
        end

        if (rd_load) begin
            if (rd_avail) begin
                dout_valid_d = 1'b1;
                dout_d       = mem_q[rb_q][rcnt_q];
                dout_idx_d   = rcnt_q;
                dout_last_d  = (rcnt_q == 6'd63);
                rcnt_d       = rcnt_q + 6'd1;
                if (rcnt_q == 6'd63) begin
                    bank_d[rb_q] = EMPTY;
                    rb_d         = ~rb_q;
                end else begin
                    bank_d[rb_q] = DRAINING;
                end
            end else begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            wcnt_q       <= 6'd0;
            rcnt_q       <= 6'd0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_idx_q   <= 6'd0;
            dout_last_q  <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            dout_idx_q   <= dout_idx_d;
            dout_last_q  <= dout_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wb_q][ZZ[wcnt_q]] <= din;
        end
    end

endmodule
